// File: rtl/zrb_uart_rx_os8.sv
// UART receiver with 8x oversampling and 3-sample majority vote per bit.
// Ports:
//   clk        - single clock, all logic on posedge
//   reset      - synchronous active-low reset
//   clk_en     - 8x-baud tick, one clk wide
//   rx         - asynchronous serial line, idle high
//   rd_en      - consumer acknowledge of the held byte
//   data_out   - received byte, LSB-first, bits above DATA_BITS-1 zero
//   valid      - data_out/parity_err/frame_err hold an unread frame
//   parity_err - parity mismatch of the held frame (0 when PARITY="NO")
//   frame_err  - a stop bit of the held frame was sampled 0
//   overrun    - sticky: a completed frame was dropped
//   busy       - receiver is not idle
module zrb_uart_rx_os8 #(
    parameter int unsigned DATA_BITS = 8,
    parameter string       PARITY    = "NO",
    parameter int unsigned STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk_en,
    input  logic       rx,
    input  logic       rd_en,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned OS_W   = 3;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned BYTE_W = 8;

    localparam bit PAR_EN  = (PARITY != "NO");
    localparam bit PAR_ODD = (PARITY == "ODD");

    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t              state, state_n;
    logic [OS_W-1:0]     os_cnt, os_n;
    logic [CNT_W-1:0]    bit_cnt, bit_n;
    logic [2:0]          samp, samp_n;
    logic [BYTE_W-1:0]   shreg, shreg_n;
    logic                perr_acc, perr_n;
    logic                ferr_acc, ferr_n;
    logic                rx_meta, rx_s;
    logic                maj_c;
    logic                done_c;

    // Majority of the three mid-bit samples
    assign maj_c = (samp[0] & samp[1]) | (samp[0] & samp[2]) | (samp[1] & samp[2]);

    // Next-state and datapath update; everything advances only on clk_en
    always_comb begin
        state_n = state;
        os_n    = os_cnt;
        bit_n   = bit_cnt;
        samp_n  = samp;
        shreg_n = shreg;
        perr_n  = perr_acc;
        ferr_n  = ferr_acc;
        done_c  = 1'b0;
        if (clk_en) begin
            if (state == ST_IDLE) begin
                if (!rx_s) begin
                    state_n = ST_START;
                    os_n    = '0;
                    bit_n   = '0;
                    shreg_n = '0;
                    perr_n  = 1'b0;
                    ferr_n  = 1'b0;
                end
            end else begin
                os_n = os_cnt + OS_W'(1);
                if (os_cnt == OS_W'(3)) samp_n[0] = rx_s;
                if (os_cnt == OS_W'(4)) samp_n[1] = rx_s;
                if (os_cnt == OS_W'(5)) samp_n[2] = rx_s;
                if (os_cnt == OS_W'(7)) begin
                    case (state)
                        ST_START: begin
                            // A high majority means a glitch, not a start bit
                            state_n = maj_c ? ST_IDLE : ST_DATA;
                            bit_n   = '0;
                        end
                        ST_DATA: begin
                            shreg_n[bit_cnt] = maj_c;
                            if (bit_cnt == LAST_DATA) begin
                                bit_n   = '0;
                                state_n = PAR_EN ? ST_PARITY : ST_STOP;
                            end else begin
                                bit_n = bit_cnt + CNT_W'(1);
                            end
                        end
                        ST_PARITY: begin
                            perr_n  = (^shreg) ^ maj_c ^ PAR_ODD;
                            bit_n   = '0;
                            state_n = ST_STOP;
                        end
                        ST_STOP: begin
                            ferr_n = ferr_acc | ~maj_c;
                            if (bit_cnt == LAST_STOP) begin
                                state_n = ST_IDLE;
                                done_c  = 1'b1;
                            end else begin
                                bit_n = bit_cnt + CNT_W'(1);
                            end
                        end
                        default: state_n = ST_IDLE;
                    endcase
                end
            end
        end
    end

    // State, datapath and output registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_meta    <= 1'b1;
            rx_s       <= 1'b1;
            state      <= ST_IDLE;
            os_cnt     <= '0;
            bit_cnt    <= '0;
            samp       <= '0;
            shreg      <= '0;
            perr_acc   <= 1'b0;
            ferr_acc   <= 1'b0;
            data_out   <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            rx_meta  <= rx;
            rx_s     <= rx_meta;
            state    <= state_n;
            os_cnt   <= os_n;
            bit_cnt  <= bit_n;
            samp     <= samp_n;
            shreg    <= shreg_n;
            perr_acc <= perr_n;
            ferr_acc <= ferr_n;
            busy     <= (state_n != ST_IDLE);
            if (done_c && (!valid || rd_en)) begin
                data_out   <= shreg_n;
                parity_err <= PAR_EN & perr_n;
                frame_err  <= ferr_n;
                valid      <= 1'b1;
                if (rd_en) overrun <= 1'b0;
            end else if (done_c) begin
                // Held frame unread: drop the new one
                overrun <= 1'b1;
            end else if (rd_en && valid) begin
                valid      <= 1'b0;
                parity_err <= 1'b0;
                frame_err  <= 1'b0;
                overrun    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_zrb_uart_rx_os8.sv
// Directed bench for zrb_uart_rx_os8: three instances (8N1, 8E1, 7O2),
// expected frames queued at send time and popped when valid rises.
module tb_zrb_uart_rx_os8;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       clk_en = 1'b0;
    logic [1:0] div = 2'd0;
    logic       rx_l [3];
    logic       rd   [3];
    logic [7:0] dout [3];
    logic       val  [3];
    logic       perr [3];
    logic       ferr [3];
    logic       ovr  [3];
    logic       bsy  [3];

    exp_t sb[$];
    int   vectors = 0;
    int   errors  = 0;

    always #5 clk = ~clk;

    // 8x tick: one clk wide every 4 clocks
    always @(posedge clk) begin
        div    <= div + 2'd1;
        clk_en <= (div == 2'd3);
    end

    zrb_uart_rx_os8 #(.DATA_BITS(8), .PARITY("NO"), .STOP_BITS(1)) dut_n (
        .clk(clk), .reset(reset), .clk_en(clk_en), .rx(rx_l[0]), .rd_en(rd[0]),
        .data_out(dout[0]), .valid(val[0]), .parity_err(perr[0]),
        .frame_err(ferr[0]), .overrun(ovr[0]), .busy(bsy[0]));

    zrb_uart_rx_os8 #(.DATA_BITS(8), .PARITY("EVEN"), .STOP_BITS(1)) dut_e (
        .clk(clk), .reset(reset), .clk_en(clk_en), .rx(rx_l[1]), .rd_en(rd[1]),
        .data_out(dout[1]), .valid(val[1]), .parity_err(perr[1]),
        .frame_err(ferr[1]), .overrun(ovr[1]), .busy(bsy[1]));

    zrb_uart_rx_os8 #(.DATA_BITS(7), .PARITY("ODD"), .STOP_BITS(2)) dut_o (
        .clk(clk), .reset(reset), .clk_en(clk_en), .rx(rx_l[2]), .rd_en(rd[2]),
        .data_out(dout[2]), .valid(val[2]), .parity_err(perr[2]),
        .frame_err(ferr[2]), .overrun(ovr[2]), .busy(bsy[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic drive_bit(input int idx, input logic v);
        rx_l[idx] = v;
        repeat (32) @(negedge clk);
    endtask

    // Called at a negedge; starts the frame so the start-detect tick is the 3rd posedge
    task automatic send_frame(input int idx, input logic [7:0] d, input int nbits,
                              input int pmode, input logic pflip, input logic s1,
                              input logic s2, input int nstop, input bit post);
        logic [7:0] dm;
        logic       p;
        exp_t       e;
        dm = 8'h00;
        for (int i = 0; i < nbits; i++) dm[i] = d[i];
        p = (^dm) ^ (pmode == 2) ^ pflip;
        if (post) begin
            e.d  = dm;
            e.pe = (pmode != 0) && pflip;
            e.fe = !s1 || (nstop == 2 && !s2);
            sb.push_back(e);
        end
        while (div != 2'd2) @(negedge clk);
        drive_bit(idx, 1'b0);
        for (int i = 0; i < nbits; i++) drive_bit(idx, dm[i]);
        if (pmode != 0) drive_bit(idx, p);
        drive_bit(idx, s1);
        if (nstop == 2) drive_bit(idx, s2);
        rx_l[idx] = 1'b1;
    endtask

    task automatic check_frame(input int idx, input string tag);
        int   n;
        exp_t e;
        n = 0;
        while (!val[idx] && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".valid"}, 32'(val[idx]), 32'd1);
        if (sb.size() == 0) begin
            vectors++;
            errors++;
            $error("FAIL %s.queue: observed empty expected entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, ".data"},   32'(dout[idx]), 32'(e.d));
            chk({tag, ".parity"}, 32'(perr[idx]), 32'(e.pe));
            chk({tag, ".frame"},  32'(ferr[idx]), 32'(e.fe));
        end
    endtask

    task automatic rd_pulse(input int idx);
        rd[idx] = 1'b1;
        @(negedge clk);
        rd[idx] = 1'b0;
    endtask

    initial begin
        repeat (100000) @(posedge clk);
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rx_l[i] = 1'b1;
            rd[i]   = 1'b0;
        end
        // Inputs toggled during reset must be ignored
        rx_l[0] = 1'b0;
        rd[0]   = 1'b1;
        repeat (3) @(negedge clk);
        rx_l[0] = 1'b1;
        rd[0]   = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst.valid",   32'(val[i]),  32'd0);
            chk("rst.data",    32'(dout[i]), 32'd0);
            chk("rst.parity",  32'(perr[i]), 32'd0);
            chk("rst.frame",   32'(ferr[i]), 32'd0);
            chk("rst.overrun", 32'(ovr[i]),  32'd0);
            chk("rst.busy",    32'(bsy[i]),  32'd0);
        end
        reset = 1'b1;
        repeat (4) @(negedge clk);

        // 8N1 0xA5 with exact latency: detect tick + 80 ticks (320 clks)
        fork
            send_frame(0, 8'hA5, 8, 0, 1'b0, 1'b1, 1'b1, 1, 1'b1);
            begin
                while (div != 2'd2) @(negedge clk);
                repeat (3) @(posedge clk);
                repeat (319) @(posedge clk);
                #1 chk("lat.before", 32'(val[0]), 32'd0);
                @(posedge clk);
                #1 chk("lat.at", 32'(val[0]), 32'd1);
            end
        join
        @(negedge clk);
        check_frame(0, "a5");
        rd_pulse(0);
        chk("a5.cleared", 32'(val[0]), 32'd0);
        chk("a5.keep",    32'(dout[0]), 32'hA5);

        // False start: two ticks low
        while (div != 2'd2) @(negedge clk);
        rx_l[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("fs.busy_on", 32'(bsy[0]), 32'd1);
        repeat (5) @(negedge clk);
        rx_l[0] = 1'b1;
        repeat (22) @(negedge clk);
        chk("fs.busy_start", 32'(bsy[0]), 32'd1);
        repeat (10) @(negedge clk);
        chk("fs.busy_off", 32'(bsy[0]), 32'd0);
        chk("fs.valid",    32'(val[0]), 32'd0);

        // Stop bit low, then an all-ones frame
        send_frame(0, 8'h3C, 8, 0, 1'b0, 1'b0, 1'b1, 1, 1'b1);
        check_frame(0, "stop0");
        rd_pulse(0);
        chk("stop0.fe_clr", 32'(ferr[0]), 32'd0);
        send_frame(0, 8'hFF, 8, 0, 1'b0, 1'b1, 1'b1, 1, 1'b1);
        check_frame(0, "ff");
        rd_pulse(0);

        // Back-to-back with no read: second frame dropped
        send_frame(0, 8'h11, 8, 0, 1'b0, 1'b1, 1'b1, 1, 1'b1);
        send_frame(0, 8'h22, 8, 0, 1'b0, 1'b1, 1'b1, 1, 1'b0);
        repeat (10) @(negedge clk);
        check_frame(0, "ovr");
        chk("ovr.flag", 32'(ovr[0]), 32'd1);
        rd_pulse(0);
        chk("ovr.clr",   32'(ovr[0]), 32'd0);
        chk("ovr.valid", 32'(val[0]), 32'd0);

        // Back-to-back with read on the completion cycle of the second
        send_frame(0, 8'h11, 8, 0, 1'b0, 1'b1, 1'b1, 1, 1'b0);
        send_frame(0, 8'h22, 8, 0, 1'b0, 1'b1, 1'b1, 1, 1'b1);
        repeat (6) @(negedge clk);
        chk("b2b.held", 32'(dout[0]), 32'h11);
        rd[0] = 1'b1;
        @(negedge clk);
        rd[0] = 1'b0;
        check_frame(0, "b2b");
        chk("b2b.ovr", 32'(ovr[0]), 32'd0);
        rd_pulse(0);

        // Reset during data bit 4 of 0x55, then a clean 0x66
        fork
            send_frame(0, 8'h55, 8, 0, 1'b0, 1'b1, 1'b1, 1, 1'b0);
            begin
                while (div != 2'd2) @(negedge clk);
                repeat (32 * 5 + 10) @(negedge clk);
                reset = 1'b0;
                repeat (3) @(negedge clk);
                chk("mid.busy",  32'(bsy[0]), 32'd0);
                chk("mid.valid", 32'(val[0]), 32'd0);
                chk("mid.data",  32'(dout[0]), 32'd0);
            end
        join
        reset = 1'b1;
        repeat (8) @(negedge clk);
        send_frame(0, 8'h66, 8, 0, 1'b0, 1'b1, 1'b1, 1, 1'b1);
        check_frame(0, "66");
        rd_pulse(0);
        repeat (400) @(negedge clk);
        chk("66.only", 32'(val[0]), 32'd0);
        rd_pulse(0);
        chk("rd_idle.valid", 32'(val[0]), 32'd0);
        chk("rd_idle.data",  32'(dout[0]), 32'h66);

        // EVEN parity: bad then good
        send_frame(1, 8'h03, 8, 1, 1'b1, 1'b1, 1'b1, 1, 1'b1);
        check_frame(1, "even_bad");
        rd_pulse(1);
        chk("even_bad.valid", 32'(val[1]),  32'd0);
        chk("even_bad.pclr",  32'(perr[1]), 32'd0);
        send_frame(1, 8'h07, 8, 1, 1'b0, 1'b1, 1'b1, 1, 1'b1);
        check_frame(1, "even_ok");
        rd_pulse(1);

        // ODD parity, 7 data bits, 2 stop bits
        send_frame(2, 8'h5A, 7, 2, 1'b0, 1'b1, 1'b1, 2, 1'b1);
        check_frame(2, "odd_ok");
        rd_pulse(2);
        send_frame(2, 8'h81, 7, 2, 1'b1, 1'b1, 1'b1, 2, 1'b1);
        check_frame(2, "odd_bad");
        rd_pulse(2);
        send_frame(2, 8'h2B, 7, 2, 1'b0, 1'b1, 1'b0, 2, 1'b1);
        check_frame(2, "odd_stop2");
        rd_pulse(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/zrb_uart_rx_os8.md
ZRB_UART_RX_OS8 -- requirements
Module: zrb_uart_rx_os8

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, data bits per frame, legal 5..8.
REQ-002 SHALL have parameter PARITY, default "NO", one of "NO", "EVEN", "ODD".
REQ-003 SHALL have parameter STOP_BITS, default 1, legal 1 or 2.
REQ-004 SHALL have port clk  input  1  single clock; all logic on posedge clk.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port clk_en  input  1  8x-baud tick, one clk wide (baud_clk_rx_en of zrb_baud_generator).
REQ-007 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-008 SHALL have port rd_en  input  1  consumer acknowledge of held byte.
REQ-009 SHALL have port data_out  output  8  received byte, LSB-first reassembled, bits above DATA_BITS-1 zero.
REQ-010 SHALL have port valid  output  1  data_out/parity_err/frame_err hold an unread frame.
REQ-011 SHALL have port parity_err  output  1  parity mismatch for held frame; constant 0 when PARITY="NO".
REQ-012 SHALL have port frame_err  output  1  any stop bit sampled 0 for held frame.
REQ-013 SHALL have port overrun  output  1  sticky: a completed frame was dropped.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-015 rx SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-016 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; state and counters advance only on cycles with clk_en=1.
REQ-017 IDLE -> START SHALL occur on a clk_en cycle with synchronized rx=0; oversample counter os_cnt (3 bits) cleared to 0.
REQ-018 In START/DATA/PARITY/STOP, os_cnt SHALL increment per clk_en; samples captured at os_cnt 3, 4, 5; bit value = majority of the three, decided at os_cnt=7.
REQ-019 START with majority 1 SHALL return to IDLE (false start), no output change.
REQ-020 START with majority 0 SHALL go to DATA; DATA SHALL take exactly DATA_BITS bits, first bit -> data bit 0.
REQ-021 After DATA, SHALL go to PARITY if PARITY!="NO", else STOP; PARITY bit SHALL be checked: EVEN -> XOR(data,parity)=0, ODD -> =1.
REQ-022 STOP SHALL take STOP_BITS bits; any stop majority 0 SHALL flag frame error; FSM SHALL continue to full end regardless.
REQ-023 Frame completion SHALL be the clk_en cycle at os_cnt=7 of the last stop bit; FSM returns to IDLE on that cycle.
REQ-024 On completion with valid=0 or rd_en=1: data_out, parity_err, frame_err SHALL load and valid SHALL be 1 from the next cycle.
REQ-025 On completion with valid=1 and rd_en=0: new frame SHALL be discarded, held outputs unchanged, overrun set to 1.
REQ-026 rd_en=1 with valid=1 and no completion SHALL clear valid, parity_err, frame_err, overrun next cycle; data_out retains its value.
REQ-027 rd_en=1 with valid=0 SHALL have no effect.
REQ-028 Frames with parity_err or frame_err SHALL still be posted (valid=1).
REQ-029 Latency: valid SHALL rise one clk after the clk_en tick that is 8*(1+DATA_BITS+P+STOP_BITS) ticks after the start-detect tick, P=0/1.
REQ-030 Back-to-back frames (next start immediately after stop) SHALL be received without loss.

Reset
REQ-031 reset=0 at posedge clk SHALL force IDLE, os_cnt=0, synchronizer flops=1, shift register=0, data_out=0, valid=0, parity_err=0, frame_err=0, overrun=0, busy=0.
REQ-032 Reset mid-frame SHALL abandon the frame without posting; reception resumes only on a new low level after reset release plus 2-clk sync delay.
REQ-033 clk_en, rx, rd_en SHALL be ignored while reset=0.

Verification
REQ-034 8N1, rx frame 0xA5 -> valid=1, data_out=0xA5, parity_err=0, frame_err=0 at REQ-029 latency (80 ticks).
REQ-035 rx low for 2 clk_en ticks then high -> FSM returns to IDLE, valid stays 0, busy pulses only during START.
REQ-036 PARITY="EVEN", data 0x03 sent with parity bit 1 -> valid=1, data_out=0x03, parity_err=1; rd_en -> valid=0, parity_err=0.
REQ-037 8N1, data 0x3C with stop bit 0 -> valid=1, data_out=0x3C, frame_err=1.
REQ-038 Frames 0x11 then 0x22, no rd_en -> data_out=0x11, overrun=1; same test with rd_en on completion cycle of 0x22 -> data_out=0x22, overrun=0.
REQ-039 reset=0 during DATA bit 4 of 0x55, then clean 0x66 -> only 0x66 posted, no errors.
